// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALUOp classes, ALUControl operations and immediate-format selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format is a pure function of the opcode, independent of FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp class plus instruction fields onto a concrete ALU operation.
module alu_decoder
    import riscv_pkg::*;
(
    input  aluop_t      alu_op_i,
    input  logic [2:0]  funct3_i,
    input  logic        op5_i,
    input  logic        funct7b5_i,
    output logic [2:0]  alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type with funct7b5 set is a subtract; addi ignores funct7b5.
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32 subset datapath with a unified,
// variable-latency memory (MemReady), plus ImmSrc and ALU control decode.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t state_q, state_d;
    state_t dec_state;
    aluop_t alu_op;
    logic   pc_update, branch;
    logic   mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // During reset the outputs decode as FETCH; write enables are masked below.
    assign dec_state = reset ? S_FETCH : state_q;

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = ALUOP_ADD;
        case (dec_state)
            S_FETCH: begin
                ir_write_raw = MemReady;
                pc_update    = MemReady;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: illegal_raw = 1'b0;
                    default: illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = MemReady;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
        endcase
    end

    assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
    assign MemWrite = mem_write_raw & ~reset;
    assign IRWrite  = ir_write_raw & ~reset;
    assign RegWrite = reg_write_raw & ~reset;
    assign Illegal  = illegal_raw & ~reset;
    assign ImmSrc   = imm_src_of(op);
    assign State    = state_q;

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (ALUControl)
    );

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock, single clock domain.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: op  input  7  opcode field, instr[6:0], of the instruction register.
REQ-004 SHALL: funct3  input  3  instr[14:12].
REQ-005 SHALL: funct7b5  input  1  instr[30].
REQ-006 SHALL: Zero  input  1  ALU zero flag.
REQ-007 SHALL: MemReady  input  1  unified memory access complete this cycle.
REQ-008 SHALL: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables/selects.
REQ-009 SHALL: ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-010 SHALL: ALUControl  output  3  ALU operation; 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 SHALL: Illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode.
REQ-012 SHALL: State  output  4  current state encoding, for debug.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH.
REQ-014 SHALL: FETCH->DECODE only when MemReady=1, else hold FETCH.
REQ-015 SHALL: DECODE transitions by op: 0000011/0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1100011->BEQ; 1101111->JAL; any other->FETCH with Illegal=1.
REQ-016 SHALL: MEMADR->MEMREAD for op=0000011, else MEMWRITE.
REQ-017 SHALL: MEMREAD->MEMWB and MEMWRITE->FETCH only when MemReady=1, else hold.
REQ-018 SHALL: MEMWB->FETCH, EXECUTER/EXECUTEI/JAL->ALUWB, ALUWB->FETCH, BEQ->FETCH unconditionally.
REQ-019 SHALL drive these signals per state; any signal not listed is 0:
  FETCH: AdrSrc=0, IRWrite=MemReady, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=MemReady.
  DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  MEMADR and EXECUTEI: ALUSrcA=10, ALUSrcB=01; ALUOp is 00 in MEMADR and 10 in EXECUTEI.
  MEMREAD: AdrSrc=1, ResultSrc=00.
  MEMWRITE: AdrSrc=1, MemWrite=MemReady.
  MEMWB: ResultSrc=01, RegWrite=1.
  ALUWB: ResultSrc=00, RegWrite=1.
  EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-020 SHALL: PCWrite = PCUpdate | (Branch & Zero), combinational in the same cycle.
REQ-021 SHALL derive ALUControl from ALUOp, funct3, op[5] and funct7b5 as follows:
  ALUOp=00 gives add; ALUOp=01 gives sub.
  ALUOp=10, funct3=000: sub if {op[5],funct7b5}=11, else add.
  ALUOp=10: funct3 010 gives slt, 110 gives or, 111 gives and, any other funct3 gives add.
REQ-022 SHALL decode ImmSrc combinationally from op, independent of state: I-type/load 00, store 01, branch 10, jal 11, other 00.
REQ-023 SHALL give these latencies in cycles with MemReady held at 1: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4, illegal 2; each MemReady=0 cycle adds 1.
REQ-024 SHALL ignore MemReady in all states other than FETCH, MEMREAD and MEMWRITE.

Reset
REQ-025 SHALL: reset=1 at a rising edge forces FETCH, taking priority over any transition, including mid-instruction.
REQ-026 SHALL: while reset=1, RegWrite, MemWrite, IRWrite, PCWrite and Illegal are all 0; other outputs follow the FETCH decode.

Structure
REQ-027 SHALL place the state encodings, opcode constants, ALUOp codes and ALUControl codes in the shared package riscv_pkg.
REQ-028 SHALL contain one sub-module, alu_decoder, which implements REQ-021; the FSM and the ImmSrc decode stay in this module.

Verification
REQ-029 SHALL cover these directed scenarios:
  lw (op=0000011), MemReady=1 -> states 0,1,2,3,4; RegWrite=1 and ResultSrc=01 in cycle 5.
  sw (op=0100011), MemReady=0 for 2 cycles in MEMWRITE -> MemWrite=0 during the wait; MemWrite=1 in the cycle after, then FETCH.
  R-type sub (funct3=000, funct7b5=1, op[5]=1) -> ALUControl=001 in EXECUTER; ALUWB then FETCH.
  beq with Zero=1 -> PCWrite=1 in BEQ; beq with Zero=0 -> PCWrite=0.
  op=1111111 -> Illegal=1 for one cycle in DECODE, then FETCH; no write enable asserted.
  reset=1 asserted in MEMREAD -> FETCH on the next edge with RegWrite=0.
